// File: rtl/hack_rom_loader.sv
// Boot loader for the Hack CPU: receives a framed program image over a byte stream,
// writes it into the instruction ROM, verifies the XOR checksum and only then releases the CPU.
module hack_rom_loader #(
   parameter int unsigned ADDR_W         = 15,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] rom_wr_addr,
   output logic [15:0]       rom_wr_data,
   output logic              rom_we,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error
);

   typedef enum logic [3:0] {
      IDLE, SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR
   } state_t;

   localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

   state_t            state, state_n;
   logic [7:0]        len_hi;
   logic [15:0]       len;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        hi_byte;
   logic [7:0]        csum;
   logic [31:0]       tmo;

   logic        timed;
   logic        tmo_hit;
   logic        last_word;
   logic [31:0] n_word;

   assign timed     = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                      (state == DATA_LO) || (state == CHECK);
   assign tmo_hit   = timed && !rx_valid && (tmo == TMO_LAST);
   assign n_word    = {16'd0, len_hi, rx_data};
   assign last_word = (32'(addr) == ({16'd0, len} - 32'd1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = SYNC;
         SYNC:    if (rx_valid && rx_data == SYNC_BYTE) state_n = LEN_HI;
         LEN_HI: begin
            if (rx_valid)     state_n = LEN_LO;
            else if (tmo_hit) state_n = ERROR;
         end
         LEN_LO: begin
            if (rx_valid) begin
               if (n_word == 32'd0 || n_word > MAX_WORDS) state_n = ERROR;
               else                                       state_n = DATA_HI;
            end else if (tmo_hit) begin
               state_n = ERROR;
            end
         end
         DATA_HI: begin
            if (rx_valid)     state_n = DATA_LO;
            else if (tmo_hit) state_n = ERROR;
         end
         DATA_LO: begin
            if (rx_valid)     state_n = last_word ? CHECK : DATA_HI;
            else if (tmo_hit) state_n = ERROR;
         end
         CHECK: begin
            if (rx_valid)     state_n = (rx_data == csum) ? RUN : ERROR;
            else if (tmo_hit) state_n = ERROR;
         end
         RUN:     if (start) state_n = SYNC;
         ERROR:   if (start) state_n = SYNC;
         default: state_n = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they change together with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         cpu_reset  <= (state_n != RUN);
         load_done  <= (state_n == RUN);
         load_error <= (state_n == ERROR);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo         <= '0;
         len_hi      <= '0;
         len         <= '0;
         addr        <= '0;
         hi_byte     <= '0;
         csum        <= '0;
         rom_we      <= 1'b0;
         rom_wr_addr <= '0;
         rom_wr_data <= '0;
      end else begin
         rom_we <= 1'b0;
         if (!timed || rx_valid) tmo <= '0;
         else                    tmo <= tmo + 32'd1;
         if (rx_valid) begin
            case (state)
               LEN_HI: len_hi <= rx_data;
               LEN_LO: begin
                  len  <= {len_hi, rx_data};
                  addr <= '0;
                  csum <= '0;
               end
               DATA_HI: begin
                  hi_byte <= rx_data;
                  csum    <= csum ^ rx_data;
               end
               DATA_LO: begin
                  rom_we      <= 1'b1;
                  rom_wr_data <= {hi_byte, rx_data};
                  rom_wr_addr <= addr;
                  csum        <= csum ^ rx_data;
                  // Holding the address on the final word keeps it from wrapping at a full-size image.
                  if (!last_word) addr <= addr + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: a table of framed images plus hand-written
// sequences for full-size image, timeout, restart corners and asynchronous reset.
module tb_hack_rom_loader;

   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned TIMEOUT = 40;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [ADDR_W-1:0] rom_wr_addr;
   logic [15:0]       rom_wr_data;
   logic              rom_we;
   logic              cpu_reset;
   logic              load_done;
   logic              load_error;

   int checks = 0;
   int errors = 0;
   int wr_violations = 0;
   logic [15:0] wdata_log[$];
   int          waddr_log[$];

   hack_rom_loader #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TIMEOUT),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rom_wr_addr(rom_wr_addr),
      .rom_wr_data(rom_wr_data),
      .rom_we(rom_we),
      .cpu_reset(cpu_reset),
      .load_done(load_done),
      .load_error(load_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rom_we) begin
         wdata_log.push_back(rom_wr_data);
         waddr_log.push_back(int'(rom_wr_addr));
         if (!cpu_reset) wr_violations++;
      end
   end

   typedef struct {
      logic [95:0] bytes;
      int          nbytes;
      int          nwr;
      logic [15:0] w0;
      logic [15:0] w1;
      logic        run;
   } frame_t;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("start_load_done", 32'(load_done), 32'd0);
      checkOutput("start_load_error", 32'(load_error), 32'd0);
   endtask

   task automatic applyStimulus(input frame_t f, input int idx);
      wdata_log.delete();
      waddr_log.delete();
      pulseStart();
      for (int i = 0; i < f.nbytes; i++) begin
         if (i == f.nbytes - 1)
            checkOutput($sformatf("f%0d_pre_cpu_reset", idx), 32'(cpu_reset), 32'd1);
         sendByte(f.bytes[95 - 8*i -: 8]);
      end
      checkOutput($sformatf("f%0d_cpu_reset", idx), 32'(cpu_reset), 32'(!f.run));
      checkOutput($sformatf("f%0d_load_done", idx), 32'(load_done), 32'(f.run));
      checkOutput($sformatf("f%0d_load_error", idx), 32'(load_error), 32'(!f.run));
      @(negedge clk);
      checkOutput($sformatf("f%0d_nwrites", idx), 32'(wdata_log.size()), 32'(f.nwr));
      if (f.nwr >= 1 && wdata_log.size() >= 1) begin
         checkOutput($sformatf("f%0d_w0_data", idx), 32'(wdata_log[0]), 32'(f.w0));
         checkOutput($sformatf("f%0d_w0_addr", idx), 32'(waddr_log[0]), 32'd0);
      end
      if (f.nwr >= 2 && wdata_log.size() >= 2) begin
         checkOutput($sformatf("f%0d_w1_data", idx), 32'(wdata_log[1]), 32'(f.w1));
         checkOutput($sformatf("f%0d_w1_addr", idx), 32'(waddr_log[1]), 32'd1);
      end
   endtask

   frame_t tbl[7];

   initial begin
      logic [7:0] hi, lo, cs;
      int bad_addr;

      tbl[0] = '{96'hA50002_0010E3_08FB00_000000, 8, 2, 16'h0010, 16'hE308, 1'b1};
      tbl[1] = '{96'hA50002_0010E3_08FA00_000000, 8, 2, 16'h0010, 16'hE308, 1'b0};
      tbl[2] = '{96'h00FF12_A50001_ABCD66_000000, 9, 1, 16'hABCD, 16'h0000, 1'b1};
      tbl[3] = '{96'hA50000_000000_000000_000000, 3, 0, 16'h0000, 16'h0000, 1'b0};
      tbl[4] = '{96'hA50011_000000_000000_000000, 3, 0, 16'h0000, 16'h0000, 1'b0};
      tbl[5] = '{96'hA50100_000000_000000_000000, 3, 0, 16'h0000, 16'h0000, 1'b0};
      tbl[6] = '{96'hA50001_123426_000000_000000, 6, 1, 16'h1234, 16'h0000, 1'b1};

      reset    = 1'b1;
      start    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("rst_load_done", 32'(load_done), 32'd0);
      checkOutput("rst_load_error", 32'(load_error), 32'd0);
      checkOutput("rst_rom_we", 32'(rom_we), 32'd0);
      checkOutput("rst_addr", 32'(rom_wr_addr), 32'd0);
      checkOutput("rst_data", 32'(rom_wr_data), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Bytes without a start pulse must be ignored in IDLE
      wdata_log.delete();
      for (int i = 0; i < 6; i++) sendByte(tbl[6].bytes[95 - 8*i -: 8]);
      @(negedge clk);
      checkOutput("idle_no_write", 32'(wdata_log.size()), 32'd0);
      checkOutput("idle_cpu_reset", 32'(cpu_reset), 32'd1);

      for (int k = 0; k < 7; k++) applyStimulus(tbl[k], k);

      // Full-size image: N == 2^ADDR_W, last write at the top address
      wdata_log.delete();
      waddr_log.delete();
      pulseStart();
      sendByte(8'hA5);
      sendByte(8'h00);
      sendByte(8'h10);
      cs = 8'h00;
      for (int i = 0; i < 16; i++) begin
         hi = 8'h40 + 8'(i);
         lo = 8'hC0 ^ 8'(i * 7);
         cs = cs ^ hi ^ lo;
         sendByte(hi);
         sendByte(lo);
      end
      sendByte(cs);
      @(negedge clk);
      checkOutput("full_nwrites", 32'(wdata_log.size()), 32'd16);
      bad_addr = 0;
      for (int i = 0; i < wdata_log.size(); i++) begin
         if (waddr_log[i] != i) bad_addr++;
         if (wdata_log[i] != {8'h40 + 8'(i), 8'hC0 ^ 8'(i * 7)}) bad_addr++;
      end
      checkOutput("full_addr_data_seq", 32'(bad_addr), 32'd0);
      if (wdata_log.size() == 16)
         checkOutput("full_last_addr", 32'(waddr_log[15]), 32'd15);
      checkOutput("full_load_done", 32'(load_done), 32'd1);

      // Start coincident with a sync byte in RUN: the byte is dropped, so the rest must not load
      wdata_log.delete();
      start    = 1'b1;
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      checkOutput("reload_cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("reload_load_done", 32'(load_done), 32'd0);
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'h12);
      sendByte(8'h34);
      sendByte(8'h26);
      @(negedge clk);
      checkOutput("coincident_no_write", 32'(wdata_log.size()), 32'd0);
      checkOutput("coincident_no_run", 32'(load_done), 32'd0);

      // Still hunting for sync; a start pulse mid-frame must be ignored
      sendByte(8'hA5);
      sendByte(8'h00);
      sendByte(8'h01);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sendByte(8'hAB);
      sendByte(8'hCD);
      sendByte(8'h66);
      @(negedge clk);
      checkOutput("midstart_nwrites", 32'(wdata_log.size()), 32'd1);
      checkOutput("midstart_run", 32'(load_done), 32'd1);

      // Timeout: exactly TIMEOUT idle cycles after the last accepted byte
      wdata_log.delete();
      pulseStart();
      sendByte(8'hA5);
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'hAB);
      repeat (TIMEOUT - 1) @(negedge clk);
      checkOutput("tmo_before", 32'(load_error), 32'd0);
      @(negedge clk);
      checkOutput("tmo_error", 32'(load_error), 32'd1);
      checkOutput("tmo_no_write", 32'(wdata_log.size()), 32'd0);
      checkOutput("tmo_cpu_reset", 32'(cpu_reset), 32'd1);

      // Asynchronous reset mid-DATA
      wdata_log.delete();
      pulseStart();
      sendByte(8'hA5);
      sendByte(8'h00);
      sendByte(8'h02);
      sendByte(8'h11);
      sendByte(8'h22);
      sendByte(8'h33);
      #2 reset = 1'b1;
      #1;
      checkOutput("arst_rom_we", 32'(rom_we), 32'd0);
      checkOutput("arst_addr", 32'(rom_wr_addr), 32'd0);
      checkOutput("arst_data", 32'(rom_wr_data), 32'd0);
      checkOutput("arst_cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("arst_load_done", 32'(load_done), 32'd0);
      checkOutput("arst_load_error", 32'(load_error), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("arst_prewrites", 32'(wdata_log.size()), 32'd1);
      wdata_log.delete();
      sendByte(8'h44);
      sendByte(8'hA5);
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'h12);
      sendByte(8'h34);
      sendByte(8'h26);
      repeat (3) @(negedge clk);
      checkOutput("arst_no_write", 32'(wdata_log.size()), 32'd0);
      checkOutput("arst_stay_reset", 32'(cpu_reset), 32'd1);

      checkOutput("no_write_while_running", 32'(wr_violations), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
